spi_xfer_arbiter: RTL
=====================

# spi_xfer_arbiter

Transaction scheduler between the AXI front-end and the SPI shift engine, in the pclk_i domain. Arbitrates AXI read and write requests, decodes each address against the four address-window registers to pick a chip select, sequences one SPI transfer per grant, and returns the response. Control and window registers come from the APB register interface; status is returned to it.

## Interface
- G_TIMEOUT_W, 16, width of the WAIT timeout counter (taken from ctrl_i[31:16]).
- pclk_i  in  1  clock.
- preset_n_i  in  1  reset, asynchronous, active-low.
- ctrl_i  in  32  control register: [0] enable, [1] priority mode (0 round-robin, 1 write-fixed), [31:16] timeout cycles (0 = off).
- win0_i..win3_i  in  32 each  window registers: [31:16] base address page, [0] window enable.
- status_o  out  32  [0] busy, [1] last decode miss, [2] last timeout, [5:4] last CS, [31:16] transaction count.
- wr_req_i / rd_req_i  in  1  request level, held until matching ack.
- wr_addr_i / rd_addr_i  in  32  request address.
- wr_data_i  in  32  write data.
- wr_ack_o / rd_ack_o  out  1  one-cycle response pulse.
- wr_err_o / rd_err_o  out  1  error, valid with ack.
- rd_data_o  out  32  read data, valid with rd_ack_o.
- spi_start_o  out  1  one-cycle transfer start.
- spi_cs_o  out  2  selected window index.
- spi_rnw_o  out  1  1 read, 0 write.
- spi_addr_o  out  16  address offset (req_addr[15:0]).
- spi_wdata_o  out  32  write data.
- spi_done_i  in  1  engine completion pulse.
- spi_rdata_i  in  32  read data, valid with spi_done_i.

## Operation
- FSM: IDLE, DECODE, START, WAIT, RESP.
- IDLE: if ctrl_i[0] and any request, grant, latch addr/data/direction, -> DECODE. Else stay.
- Arbitration: mode 1 write always wins; mode 0 on simultaneous requests grant the requester not granted last; last-grant reset = read (first contest goes to write).
- DECODE: hit when winN_i[0] and addr[31:16] == winN_i[31:16]; multiple hits -> lowest N. Hit -> START; miss -> RESP with error, no SPI access.
- START: spi_start_o = 1 one cycle; spi_cs_o/rnw/addr/wdata stable from START until RESP -> WAIT.
- WAIT: spi_done_i -> capture spi_rdata_i -> RESP. Timeout expiry -> RESP with error.
- RESP: ack pulse (+err, rd_data) to granted requester; update status [1],[2],[5:4]; increment count (wraps 0xFFFF -> 0, errors counted) -> IDLE.
- status_o[0] = 1 in any state other than IDLE.
- Clearing ctrl_i[0] mid-transaction: current transaction completes normally; no new grants.
- Requester must drop req in the cycle after its ack; IDLE samples then.

## Timing
- Reset: all outputs 0, state IDLE, count 0, last-grant read.
- Request visible in IDLE cycle 0 -> DECODE 1 -> spi_start_o cycle 2 -> WAIT from 3.
- spi_done_i in cycle D -> ack in D+1.
- Decode miss: ack+err in cycle 2.
- Timeout: counter loaded from ctrl_i[31:16] on entering WAIT, decrements per WAIT cycle; reaching 0 without done -> RESP. Done and expiry same cycle: done wins, no error.
- spi_done_i outside WAIT ignored.

## Configuration
- SPI_ARB_TIMEOUT_EN defined: timeout counter built as above.
- Undefined: no counter, WAIT leaves only on spi_done_i, status_o[2] tied 0, ctrl_i[31:16] ignored.

## Structure
- Shared package spi_if_pkg: FSM state enum, ctrl/window/status bit-field constants, CS width.
- One sub-module spi_win_decode: combinational four-window match and priority encode (hit, index).

## Test plan
- Write 0x0001_0040, win1 = 0x0001_0001, done 5 cycles after start -> spi_cs_o=1, spi_addr_o=0x0040, wr_ack_o no error, count=1.
- Read to unmapped 0x0009_0000 -> rd_ack_o+rd_err_o in cycle 2, no spi_start_o, status_o[1]=1.
- Simultaneous read+write, mode 0, three rounds -> grants W,R,W; mode 1 -> always W first.
- Timeout 8, engine silent -> ack+err 8 WAIT cycles after entry, status_o[2]=1; done on expiry cycle -> no error.
- Two windows match same page (win0, win2) -> spi_cs_o=0.
- preset_n_i asserted in WAIT -> all outputs 0 immediately, next request handled normally from IDLE.

Source files
------------

// File: rtl/spi_if_pkg.sv
// Shared types and register bit-field positions for the SPI transfer arbiter.
// Timeout logic is built only when SPI_ARB_TIMEOUT_EN is defined.
package spi_if_pkg;

    localparam int CS_W    = 2;
    localparam int NUM_WIN = 4;

    localparam int CTRL_EN      = 0;
    localparam int CTRL_MODE    = 1;
    localparam int CTRL_TMO_LSB = 16;

    localparam int WIN_EN       = 0;
    localparam int WIN_PAGE_LSB = 16;

    localparam int ST_BUSY    = 0;
    localparam int ST_MISS    = 1;
    localparam int ST_TMO     = 2;
    localparam int ST_CS_LSB  = 4;
    localparam int ST_CNT_LSB = 16;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DECODE,
        S_START,
        S_WAIT,
        S_RESP
    } state_t;

endpackage

// File: rtl/spi_win_decode.sv
// Four-window address page match; the lowest-numbered enabled matching window wins.
module spi_win_decode
    import spi_if_pkg::*;
(
    input  logic [15:0]                 page,
    input  logic [NUM_WIN-1:0]          win_en,
    input  logic [NUM_WIN-1:0][15:0]    win_page,
    output logic                        hit,
    output logic [CS_W-1:0]             idx
);

    // Scan downwards so the lowest matching index is the last one written.
    always_comb begin
        hit = 1'b0;
        idx = '0;
        for (int n = NUM_WIN - 1; n >= 0; n--) begin
            if (win_en[n] && (win_page[n] == page)) begin
                hit = 1'b1;
                idx = CS_W'(n);
            end
        end
    end

endmodule

// File: rtl/spi_xfer_arbiter.sv
// Schedules AXI read/write requests onto the SPI shift engine, one transfer per grant.
// Define SPI_ARB_TIMEOUT_EN to build the WAIT-state timeout counter.
module spi_xfer_arbiter
    import spi_if_pkg::*;
#(
    parameter int G_TIMEOUT_W = 16
) (
    input  logic        pclk_i,
    input  logic        preset_n_i,
    input  logic [31:0] ctrl_i,
    input  logic [31:0] win0_i,
    input  logic [31:0] win1_i,
    input  logic [31:0] win2_i,
    input  logic [31:0] win3_i,
    output logic [31:0] status_o,
    input  logic        wr_req_i,
    input  logic        rd_req_i,
    input  logic [31:0] wr_addr_i,
    input  logic [31:0] rd_addr_i,
    input  logic [31:0] wr_data_i,
    output logic        wr_ack_o,
    output logic        rd_ack_o,
    output logic        wr_err_o,
    output logic        rd_err_o,
    output logic [31:0] rd_data_o,
    output logic        spi_start_o,
    output logic [1:0]  spi_cs_o,
    output logic        spi_rnw_o,
    output logic [15:0] spi_addr_o,
    output logic [31:0] spi_wdata_o,
    input  logic        spi_done_i,
    input  logic [31:0] spi_rdata_i
);

    state_t state, state_n;

    logic                     last_wr, rnw_q, err_q, tmo_err_q;
    logic                     st_miss, st_tmo;
    logic [31:0]              addr_q, wdata_q, rdata_q;
    logic [CS_W-1:0]          cs_q, st_cs, dec_idx;
    logic [15:0]              cnt;
    logic                     dec_hit, go, grant_wr, tmo_exp, in_resp;
    logic [NUM_WIN-1:0]       win_en;
    logic [NUM_WIN-1:0][15:0] win_page;
    logic                     unused_bits;

    assign win_en   = {win3_i[WIN_EN], win2_i[WIN_EN], win1_i[WIN_EN], win0_i[WIN_EN]};
    assign win_page = {win3_i[31:WIN_PAGE_LSB], win2_i[31:WIN_PAGE_LSB],
                       win1_i[31:WIN_PAGE_LSB], win0_i[31:WIN_PAGE_LSB]};

    spi_win_decode u_dec (
        .page     (addr_q[31:16]),
        .win_en   (win_en),
        .win_page (win_page),
        .hit      (dec_hit),
        .idx      (dec_idx)
    );

    // Round-robin favours whoever was not granted last; mode 1 always favours writes.
    assign go       = (state == S_IDLE) && ctrl_i[CTRL_EN] && (wr_req_i || rd_req_i);
    assign grant_wr = wr_req_i && (!rd_req_i || ctrl_i[CTRL_MODE] || !last_wr);

`ifdef SPI_ARB_TIMEOUT_EN
    logic [G_TIMEOUT_W-1:0] tmo_cnt;
    logic                   tmo_on;

    always_ff @(posedge pclk_i or negedge preset_n_i) begin
        if (!preset_n_i) begin
            tmo_cnt <= '0;
            tmo_on  <= 1'b0;
        end else if (state == S_START) begin
            tmo_cnt <= ctrl_i[CTRL_TMO_LSB +: G_TIMEOUT_W];
            tmo_on  <= |ctrl_i[CTRL_TMO_LSB +: G_TIMEOUT_W];
        end else if (state == S_WAIT && tmo_cnt != '0) begin
            tmo_cnt <= tmo_cnt - G_TIMEOUT_W'(1);
        end
    end

    // Expires on the WAIT cycle in which the count would reach zero.
    assign tmo_exp     = tmo_on && (tmo_cnt == G_TIMEOUT_W'(1));
    assign unused_bits = ^{ctrl_i[CTRL_TMO_LSB-1:CTRL_MODE+1], win0_i[15:1],
                           win1_i[15:1], win2_i[15:1], win3_i[15:1]};
`else
    assign tmo_exp     = 1'b0;
    assign unused_bits = ^{ctrl_i[31:CTRL_MODE+1], win0_i[15:1],
                           win1_i[15:1], win2_i[15:1], win3_i[15:1]};
`endif

    always_ff @(posedge pclk_i or negedge preset_n_i) begin
        if (!preset_n_i) state <= S_IDLE;
        else             state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            S_IDLE:   if (go) state_n = S_DECODE;
            S_DECODE: state_n = dec_hit ? S_START : S_RESP;
            S_START:  state_n = S_WAIT;
            S_WAIT:   if (spi_done_i || tmo_exp) state_n = S_RESP;
            S_RESP:   state_n = S_IDLE;
            default:  state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge pclk_i or negedge preset_n_i) begin
        if (!preset_n_i) begin
            last_wr   <= 1'b0;
            rnw_q     <= 1'b0;
            err_q     <= 1'b0;
            tmo_err_q <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            cs_q      <= '0;
            st_miss   <= 1'b0;
            st_tmo    <= 1'b0;
            st_cs     <= '0;
            cnt       <= '0;
        end else begin
            case (state)
                S_IDLE: if (go) begin
                    last_wr   <= grant_wr;
                    rnw_q     <= !grant_wr;
                    addr_q    <= grant_wr ? wr_addr_i : rd_addr_i;
                    wdata_q   <= grant_wr ? wr_data_i : '0;
                    rdata_q   <= '0;
                    err_q     <= 1'b0;
                    tmo_err_q <= 1'b0;
                end
                S_DECODE: begin
                    cs_q  <= dec_idx;
                    err_q <= !dec_hit;
                end
                S_WAIT: begin
                    if (spi_done_i) begin
                        rdata_q <= spi_rdata_i;
                    end else if (tmo_exp) begin
                        err_q     <= 1'b1;
                        tmo_err_q <= 1'b1;
                    end
                end
                S_RESP: begin
                    st_miss <= err_q && !tmo_err_q;
                    st_tmo  <= tmo_err_q;
                    st_cs   <= cs_q;
                    cnt     <= cnt + 16'd1;
                end
                default: ;
            endcase
        end
    end

    assign in_resp     = (state == S_RESP);
    assign wr_ack_o    = in_resp && !rnw_q;
    assign rd_ack_o    = in_resp && rnw_q;
    assign wr_err_o    = wr_ack_o && err_q;
    assign rd_err_o    = rd_ack_o && err_q;
    assign rd_data_o   = rdata_q;

    assign spi_start_o = (state == S_START);
    assign spi_cs_o    = cs_q;
    assign spi_rnw_o   = rnw_q;
    assign spi_addr_o  = addr_q[15:0];
    assign spi_wdata_o = wdata_q;

    assign status_o = {cnt, 10'd0, st_cs, 1'b0, st_tmo, st_miss, (state != S_IDLE)};

endmodule
